// File: rtl/jar_sequence_player.sv
// Digit sequence player: steps through a table of hex digits at a selectable
// rate and shows the current digit on a 7-segment output. It can loop forwards
// or backwards, or play once and stop in DONE.
//
// state | meaning
// IDLE  | paused, prescaler held, waiting for run
// RUN   | prescaler counting, index steps on each tick
// DONE  | one-shot finished at end position, flag held high until run drops
module jar_sequence_player #(
  parameter int                 DEPTH = 32,
  parameter logic [DEPTH*4-1:0] SEQ   = (DEPTH*4)'(128'hFEDCBA9876543210FEDCBA9876543210)
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int             IW   = $clog2(DEPTH);
  localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic       clk;
  logic       rst_n;
  logic       oe;
  logic       run;
  logic       dir;
  logic [1:0] speed;
  logic       oneshot;

  assign clk     = io_in[0];
  assign rst_n   = io_in[1];
  assign oe      = io_in[2];
  assign run     = io_in[3];
  assign dir     = io_in[4];
  assign speed   = io_in[6:5];
  assign oneshot = io_in[7];

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [5:0]    presc_q;
  logic [3:0]    digit_q;
  logic          wrap_q;
  logic [5:0]    presc_lim;
  logic          tick;
  logic          at_end;
  logic          done_hit;
  logic [6:0]    seg_dec;

  // Terminal count for the prescaler; ">=" so lowering speed mid-count ticks at once.
  always_comb begin
    presc_lim = 6'd0;
    case (speed)
      2'd0: presc_lim = 6'd0;
      2'd1: presc_lim = 6'd3;
      2'd2: presc_lim = 6'd15;
      2'd3: presc_lim = 6'd63;
      default: presc_lim = 6'd0;
    endcase
  end

  // Next-state and next-index logic; index freezes on the tick that enters DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick     = (state_q == RUN) && (presc_q >= presc_lim);
    at_end   = dir ? (idx_q == '0) : (idx_q == LAST);
    done_hit = tick && oneshot && at_end;

    if (tick && !done_hit) begin
      if (dir)
        idx_d = (idx_q == '0) ? LAST : idx_q - 1'b1;
      else
        idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end

    case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: begin
        if (!run)          state_d = IDLE;
        else if (done_hit) state_d = DONE;
      end
      DONE: begin
        if (!run) begin
          state_d = IDLE;
          idx_d   = dir ? LAST : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, prescaler, digit and wrap-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      presc_q <= 6'd0;
      digit_q <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == RUN)
        presc_q <= tick ? 6'd0 : presc_q + 6'd1;
      digit_q <= SEQ[{idx_q, 2'b00} +: 4];
      wrap_q  <= tick && !done_hit && at_end;
    end
  end

  // Hex digit to active-high segments, bit0 = a .. bit6 = g.
  always_comb begin
    seg_dec = 7'h00;
    case (digit_q)
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;
      4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;
      4'hF: seg_dec = 7'h71;
      default: seg_dec = 7'h00;
    endcase
  end

  // Flag is the loop wrap pulse or the one-shot done level; never gated by oe.
  always_comb begin
    io_out[6:0] = oe ? seg_dec : 7'h00;
    io_out[7]   = wrap_q | (state_q == DONE);
  end

endmodule

// File: doc/jar_sequence_player.md
JAR_SEQUENCE_PLAYER -- requirements
Module: jar_sequence_player

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of sequence steps, legal range 2..32.
REQ-002 SHALL have parameter SEQ, width DEPTH*4, meaning the digit table; digit i = SEQ[4i+3:4i]; default digit i = i mod 16.
REQ-003 SHALL have port io_in[0] clk, input, 1 bit: the single clock, rising edge; one clock only.
REQ-004 SHALL have port io_in[1] reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port io_in[2] oe, input, 1 bit: segment output enable.
REQ-006 SHALL have port io_in[3] run, input, 1 bit: 1 = advance, 0 = pause.
REQ-007 SHALL have port io_in[4] dir, input, 1 bit: 0 = forward, 1 = backward.
REQ-008 SHALL have port io_in[6:5] speed, input, 2 bits: step divisor select.
REQ-009 SHALL have port io_in[7] oneshot, input, 1 bit: 0 = loop mode, 1 = one-shot mode.
REQ-010 SHALL have port io_out[6:0] segments, output, 7 bits: active-high, bit0 = a through bit6 = g.
REQ-011 SHALL have port io_out[7] flag, output, 1 bit: wrap pulse in loop mode, done level in one-shot mode.

Function
REQ-012 SHALL hold an index register of clog2(DEPTH) bits, a 6-bit prescaler, a 4-bit digit register and a 3-state FSM (IDLE, RUN, DONE).
REQ-013 SHALL assert a step tick when the FSM is in RUN and prescaler >= D-1, where D = 1, 4, 16 or 64 for speed 0..3; on a tick the prescaler clears, otherwise it increments.
REQ-014 SHALL hold the prescaler, without clearing it, whenever the FSM is not in RUN.
REQ-015 SHALL use the ">=" comparison so that lowering speed mid-count never stalls.
REQ-016 SHALL, on a tick in forward mode, set index to index+1, wrapping DEPTH-1 -> 0.
REQ-017 SHALL, on a tick in backward mode, set index to index-1, wrapping 0 -> DEPTH-1.
REQ-018 SHALL apply wrap at DEPTH, not at the power of two, for non-power-of-two DEPTH.
REQ-019 SHALL sample dir at every tick, so a direction change applies at the next step.
REQ-020 SHALL implement these FSM transitions: IDLE -> RUN when run=1; RUN -> IDLE when run=0; RUN -> DONE on a tick with oneshot=1 and index at the end position (DEPTH-1 forward, 0 backward); DONE -> IDLE when run=0.
REQ-021 SHALL leave index unchanged on the RUN -> DONE tick.
REQ-022 SHALL, on DONE -> IDLE, reload index to the start position: 0 if dir=0, DEPTH-1 if dir=1.
REQ-023 SHALL register digit <= SEQ digit[index] every cycle, giving 1-cycle latency from an index change to a digit change.
REQ-024 SHALL drive segments combinationally from the digit register when oe=1, and drive 7'h00 when oe=0.
REQ-025 SHALL decode digits 0..F to segments 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-026 SHALL, in loop mode, pulse flag high for exactly one cycle, in the cycle after a wrapping tick.
REQ-027 SHALL, in one-shot mode, hold flag = 1 while in DONE and 0 otherwise.
REQ-028 SHALL leave flag independent of oe.
REQ-029 SHALL, if oneshot falls while in DONE, leave the FSM in DONE until run=0.
REQ-030 SHALL, if oneshot rises mid-RUN, check the end condition from the next tick onward.

Reset
REQ-031 SHALL, while reset_n=0 and regardless of clk, hold index=0, prescaler=0, digit=0, FSM=IDLE and flag=0.
REQ-032 SHALL drive segments = 7'h3F during reset if oe=1.
REQ-033 SHALL, when reset asserts mid-RUN or in DONE, abort immediately with no pending tick or flag pulse.
REQ-034 SHALL release reset cleanly on any clock phase; the first tick requires run=1 and a full divisor count after release.

Verification
REQ-035 SHALL cover: defaults, speed=0, run=1, dir=0, oneshot=0, oe=1 -> segments 3F,06,5B,... one digit per cycle; after the step to index 0 (digit 0 reloaded), flag high for 1 cycle; period 32 cycles.
REQ-036 SHALL cover: speed=2, run=1 -> index advances every 16 cycles; run=0 for 5 cycles mid-count, then run=1 -> the next step is delayed by exactly 5 cycles.
REQ-037 SHALL cover: DEPTH=5, dir=1, loop mode -> index sequence 0,4,3,2,1,0; flag pulses after the 0 -> 4 step.
REQ-038 SHALL cover: oneshot=1, dir=0, speed=0 -> stops at digit F in DONE with flag=1; run=0 -> IDLE, flag=0, index=0.
REQ-039 SHALL cover: speed changed from 3 to 0 with prescaler=40 -> a tick on the next cycle; oe=0 -> segments=00 while index keeps advancing.
REQ-040 SHALL cover: reset_n pulsed low asynchronously mid-run -> immediately index=0, segments=3F, flag=0.
